// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for DIV / DIVU. It sits beside the EX
//   stage. EX raises start_i and holds the pipeline while stall_o is high.
//   When ready_o rises, EX writes result_o to HI/LO and drops start_i.
//
// Ports
//   cpu_clk_75M  in   clock, rising edge
//   cpu_rst_n    in   asynchronous active-low reset
//   start_i      in   divide request; held high until ready_o is seen
//   signed_i     in   1 = DIV (signed), 0 = DIVU; sampled with start_i in IDLE
//   annul_i      in   abort (exception/flush); overrides everything but reset
//   opdata1_i    in   dividend; sampled with start_i in IDLE
//   opdata2_i    in   divisor;  sampled with start_i in IDLE
//   result_o     out  {remainder, quotient}; upper half to HI, lower to LO
//   ready_o      out  result_o valid
//   stall_o      out  pipeline stall request
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                cpu_clk_75M,
  input  logic                cpu_rst_n,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic                annul_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stall_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  rem_reg;    // partial remainder
  logic [DATA_W-1:0]  dvd_reg;    // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]  dsr_reg;    // divisor magnitude
  logic               neg_q_reg;  // negate quotient at the end
  logic               neg_r_reg;  // negate remainder at the end

  // Operand magnitudes; only signed divides take the absolute value.
  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic              op1_neg;
  logic              op2_neg;

  assign op1_neg = signed_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_i & opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step. The shifted remainder needs DATA_W+1 bits since it
  // can reach 2*divisor-1. When there is no borrow the true difference is
  // below the divisor, so the low DATA_W bits of the subtraction are exact.
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W-1:0] trial;
  logic              borrow;
  logic [DATA_W-1:0] rem_next;

  assign rem_shift = {rem_reg, dvd_reg[DATA_W-1]};
  assign borrow    = rem_shift < {1'b0, dsr_reg};
  assign trial     = rem_shift[DATA_W-1:0] - dsr_reg;
  assign rem_next  = borrow ? rem_shift[DATA_W-1:0] : trial;

  // Sign fix-up: quotient negative when operand signs differ, remainder
  // follows the dividend.
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;

  assign quot_fix = neg_q_reg ? (~dvd_reg + 1'b1) : dvd_reg;
  assign rem_fix  = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

  // Stall drops in END so EX can capture the result and release start_i.
  assign stall_o = ((state_reg == S_IDLE) & start_i & ~annul_i)
                 | (state_reg == S_ON)
                 | (state_reg == S_BYZERO);

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      dvd_reg   <= '0;
      dsr_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else if (annul_i) begin
      state_reg <= S_IDLE;
      ready_o   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          ready_o <= 1'b0;
          if (start_i) begin
            if (opdata2_i == '0) begin
              state_reg <= S_BYZERO;
            end else begin
              state_reg <= S_ON;
              cnt_reg   <= '0;
              rem_reg   <= '0;
              dvd_reg   <= op1_abs;
              dsr_reg   <= op2_abs;
              neg_q_reg <= op1_neg ^ op2_neg;
              neg_r_reg <= op1_neg;
            end
          end
        end
        S_BYZERO: begin
          // Divide by zero is not trapped; the result is fixed at zero.
          rem_reg   <= '0;
          dvd_reg   <= '0;
          neg_q_reg <= 1'b0;
          neg_r_reg <= 1'b0;
          state_reg <= S_END;
        end
        S_ON: begin
          rem_reg <= rem_next;
          dvd_reg <= {dvd_reg[DATA_W-2:0], ~borrow};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_reg <= S_END;
          end
        end
        S_END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quot_fix};
          end else begin
            state_reg <= S_IDLE;
            ready_o   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst_n   = 1'b0;
  logic        start_i     = 1'b0;
  logic        signed_i    = 1'b0;
  logic        annul_i     = 1'b0;
  logic [31:0] opdata1_i   = '0;
  logic [31:0] opdata2_i   = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

  div_unit #(.DATA_W(32)) dut (
    .cpu_clk_75M (cpu_clk_75M),
    .cpu_rst_n   (cpu_rst_n),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_o     (stall_o)
  );

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  // Reference: plain language-level division on 64-bit integers.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Launch one divide at a negedge, follow it edge by edge, check stall/ready
  // timing and the result, then drop start_i and check the return to idle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit scramble, input logic [63:0] exp);
    int lat;
    int stall_edges;
    lat         = (b == 32'd0) ? 2 : 33;
    stall_edges = (b == 32'd0) ? 1 : 32;
    @(negedge cpu_clk_75M);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    #1 check1("stall_at_start", stall_o, 1'b1);
    for (int k = 0; k <= lat; k++) begin
      @(negedge cpu_clk_75M);   // just after edge k
      check1("ready_timing", ready_o, (k >= lat) ? 1'b1 : 1'b0);
      check1("stall_timing", stall_o, (k < stall_edges) ? 1'b1 : 1'b0);
      if (scramble && k == 0) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom_range(0, 3);
        signed_i  = ~signed_i;
      end
    end
    check64("result", result_o, exp);
    $display("div a=%h b=%h signed=%0d result=%h expected=%h", a, b, s, result_o, exp);
    start_i = 1'b0;
    @(negedge cpu_clk_75M);
    check1("ready_drop", ready_o, 1'b0);
    check64("result_hold", result_o, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    // Reset state
    #12;
    check1("rst_ready", ready_o, 1'b0);
    check1("rst_stall", stall_o, 1'b0);
    check64("rst_result", result_o, 64'd0);
    @(negedge cpu_clk_75M);
    cpu_rst_n = 1'b1;

    // Directed vectors
    run_div(32'd7, 32'd2, 1'b0, 1'b0, 64'h00000001_00000003);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFD);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 64'h00000001_FFFFFFFD);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 64'h00000000_FFFFFFFF);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h00000000_80000000);
    run_div(32'd12345, 32'd0, 1'b0, 1'b0, 64'd0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, ref_div(32'hFFFF_FFF9, 32'd2, 1'b0));

    // start_i with annul_i in IDLE is ignored
    @(negedge cpu_clk_75M);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    #1 check1("annul_idle_stall", stall_o, 1'b0);
    @(negedge cpu_clk_75M);
    start_i = 1'b0; annul_i = 1'b0;
    #1 check1("annul_idle_state", stall_o, 1'b0);

    // annul_i at cycle 10 of ON
    @(negedge cpu_clk_75M);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd5000; opdata2_i = 32'd3;
    for (int k = 0; k <= 10; k++) @(negedge cpu_clk_75M);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge cpu_clk_75M);
    annul_i = 1'b0;
    check1("annul_on_stall", stall_o, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge cpu_clk_75M);
      check1("annul_no_ready", ready_o, 1'b0);
    end
    run_div(32'd100, 32'd7, 1'b0, 1'b0, 64'h00000002_0000000E);

    // Asynchronous reset mid-ON
    @(negedge cpu_clk_75M);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int k = 0; k < 5; k++) @(negedge cpu_clk_75M);
    start_i = 1'b0;
    #2 cpu_rst_n = 1'b0;
    #1;
    check1("arst_ready", ready_o, 1'b0);
    check1("arst_stall", stall_o, 1'b0);
    check64("arst_result", result_o, 64'd0);
    cpu_rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge cpu_clk_75M);
      check1("arst_no_ready", ready_o, 1'b0);
    end
    run_div(32'd1000, 32'd3, 1'b0, 1'b0, 64'h00000001_0000014D);

    // Randomized divides against the reference model
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 15);
        1:       rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_div(ra, rb, rs, (n % 3) == 0, ref_div(ra, rb, rs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
